field_gatherer: RTL

FIELD_GATHERER -- requirements
Module: field_gatherer

---
 rtl/pic_pkg.sv | 69 ++++++
 rtl/gather_fifo.sv | 53 +++++
 rtl/field_gatherer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared particle-in-cell types and helpers for the field gather path.
// Positions are 8.8 fixed point on a periodic 256x256 grid.
package pic_pkg;
   localparam int GRID_BITS    = 8;
   localparam int FRAC_BITS    = 8;
   localparam int GATHER_DEPTH = 4;

   localparam int POS_BITS    = GRID_BITS + FRAC_BITS;
   localparam int FIELD_BITS  = 16;
   localparam int WEIGHT_BITS = 2 * FRAC_BITS + 1;
   localparam int PROD_BITS   = WEIGHT_BITS + 1 + FIELD_BITS;
   localparam int ACC_BITS    = PROD_BITS + 1;

   typedef logic [2*GRID_BITS-1:0] addr_t;
   typedef logic [WEIGHT_BITS-1:0] weight_t;

   typedef struct packed {
      logic [POS_BITS-1:0] pos_x;
      logic [POS_BITS-1:0] pos_y;
   } particle_t;

   typedef struct packed {
      logic signed [FIELD_BITS-1:0] ex;
      logic signed [FIELD_BITS-1:0] ey;
   } field_t;

   typedef struct packed {
      particle_t     particle;
      weight_t [3:0] w;
   } pending_t;

   typedef struct packed {
      particle_t particle;
      field_t    field;
   } result_t;

   // k[0] steps x, k[1] steps y; the 8-bit add wraps for the periodic grid.
   function automatic addr_t corner_addr(input logic [GRID_BITS-1:0] cx,
                                         input logic [GRID_BITS-1:0] cy,
                                         input logic [1:0] k);
      logic [GRID_BITS-1:0] x;
      logic [GRID_BITS-1:0] y;
      x = cx + {{(GRID_BITS-1){1'b0}}, k[0]};
      y = cy + {{(GRID_BITS-1){1'b0}}, k[1]};
      return {y, x};
   endfunction

   function automatic weight_t mul_weight(input logic [FRAC_BITS:0] a,
                                          input logic [FRAC_BITS:0] b);
      logic [2*FRAC_BITS+1:0] t;
      t = {{(FRAC_BITS+1){1'b0}}, a} * {{(FRAC_BITS+1){1'b0}}, b};
      return t[WEIGHT_BITS-1:0];
   endfunction

   function automatic weight_t [3:0] bilinear_weights(input logic [FRAC_BITS-1:0] fx,
                                                      input logic [FRAC_BITS-1:0] fy);
      logic [FRAC_BITS:0] px, py, nx, ny;
      weight_t [3:0] w;
      px = {1'b0, fx};
      py = {1'b0, fy};
      nx = (FRAC_BITS+1)'(1 << FRAC_BITS) - px;
      ny = (FRAC_BITS+1)'(1 << FRAC_BITS) - py;
      w[0] = mul_weight(nx, ny);
      w[1] = mul_weight(px, ny);
      w[2] = mul_weight(nx, py);
      w[3] = mul_weight(px, py);
      return w;
   endfunction
endpackage

// File: rtl/gather_fifo.sv
// Small in-order FIFO with registered storage; head is visible whenever non-empty.
module gather_fifo
   import pic_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW:0]      used;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (used == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (used != (PW+1)'(DEPTH));
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         used   <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   used <= used + (PW+1)'(1);
            2'b01:   used <= used - (PW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/field_gatherer.sv
// Bilinear field gather: issues four corner reads per particle and combines the
// returned corner fields with precomputed weights in a two-stage pipeline.
module field_gatherer
   import pic_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            particle_valid,
   input  particle_t       particle_in,
   output logic            particle_ready,
   output logic            grid_req_valid,
   output addr_t  [3:0]    grid_addr_out,
   input  logic            grid_rsp_valid,
   input  field_t [3:0]    grid_field_in,
   output logic            out_valid,
   input  logic            out_ready,
   output particle_t       particle_out,
   output field_t          field_out,
   output logic            err_rsp
);
   logic [2:0] count;
   logic       accept;
   logic       out_hs;
   logic       rsp_take;

   pending_t   pend_push_data;
   pending_t   pend_head;
   logic       pend_empty;

   logic                        s1_valid;
   particle_t                   s1_particle;
   logic signed [PROD_BITS-1:0] s1_ex [4];
   logic signed [PROD_BITS-1:0] s1_ey [4];

   logic signed [ACC_BITS-1:0] acc_ex;
   logic signed [ACC_BITS-1:0] acc_ey;
   result_t                    sum_result;
   result_t                    out_head;
   logic                       out_empty;

   assign out_valid = !out_empty && !rst;
   assign out_hs    = out_valid && out_ready;
   // A slot retiring through the output handshake is reusable in the same
   // cycle, which is what lets one particle per cycle flow at minimum latency.
   assign particle_ready = !rst && ((count < 3'(GATHER_DEPTH)) || out_hs);
   assign accept   = particle_valid && particle_ready;
   assign rsp_take = grid_rsp_valid && !pend_empty;

   assign pend_push_data.particle = particle_in;
   assign pend_push_data.w = bilinear_weights(particle_in.pos_x[FRAC_BITS-1:0],
                                              particle_in.pos_y[FRAC_BITS-1:0]);

   gather_fifo #(.WIDTH($bits(pending_t)), .DEPTH(GATHER_DEPTH)) u_pend_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (pend_push_data),
      .pop       (rsp_take),
      .head      (pend_head),
      .empty     (pend_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         count          <= '0;
         grid_req_valid <= 1'b0;
         err_rsp        <= 1'b0;
         s1_valid       <= 1'b0;
      end else begin
         grid_req_valid <= accept;
         s1_valid       <= rsp_take;
         if (grid_rsp_valid && pend_empty) err_rsp <= 1'b1;
         case ({accept, out_hs})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < 4; k++) begin
            grid_addr_out[k] <= corner_addr(particle_in.pos_x[POS_BITS-1:FRAC_BITS],
                                            particle_in.pos_y[POS_BITS-1:FRAC_BITS],
                                            2'(k));
         end
      end
      if (rsp_take) begin
         s1_particle <= pend_head.particle;
         for (int k = 0; k < 4; k++) begin
            s1_ex[k] <= PROD_BITS'($signed({1'b0, pend_head.w[k]})) * PROD_BITS'(grid_field_in[k].ex);
            s1_ey[k] <= PROD_BITS'($signed({1'b0, pend_head.w[k]})) * PROD_BITS'(grid_field_in[k].ey);
         end
      end
   end

   always_comb begin
      acc_ex = '0;
      acc_ey = '0;
      for (int k = 0; k < 4; k++) begin
         acc_ex = acc_ex + ACC_BITS'(s1_ex[k]);
         acc_ey = acc_ey + ACC_BITS'(s1_ey[k]);
      end
      sum_result.particle = s1_particle;
      // Weights sum to 2^16, so the arithmetic shift is a floor-normalise.
      sum_result.field.ex = FIELD_BITS'(acc_ex >>> (2 * FRAC_BITS));
      sum_result.field.ey = FIELD_BITS'(acc_ey >>> (2 * FRAC_BITS));
   end

   gather_fifo #(.WIDTH($bits(result_t)), .DEPTH(GATHER_DEPTH)) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s1_valid),
      .push_data (sum_result),
      .pop       (out_hs),
      .head      (out_head),
      .empty     (out_empty)
   );

   assign particle_out = out_head.particle;
   assign field_out    = out_head.field;
endmodule
